ac_upsp_wbeat_serializer: RTL and testbench
===========================================

// Module: ac_upsp_wbeat_serializer
// PURPOSE
// Receiving end of the upsampler write channel (upsp_ac_w*) on the access-controller side.
// - Accepts 96-bit beats, each holding four 24-bit RGB output pixels.
// - Buffers them in a small FIFO and serialises them into a one-pixel-per-beat stream for the frame writer.
// - Output pixels carry start-of-frame and end-of-line markers.
// PARAMETERS
// BUFFER_WIDTH    24    bits per pixel {R[23:16],G[15:8],B[7:0]}
// DST_IMG_WIDTH   3840  output pixels per line; must be a multiple of 4
// DST_IMG_HEIGHT  2160  output lines per frame
// FIFO_DEPTH      4     FIFO entries, each one 96-bit beat; power of 2, >=2
// PORTS
// clk             in   1     clock
// rst_n           in   1     async active-low reset
// upsp_ac_wdata   in   96    {pix0,pix1,pix2,pix3}; pix0 in [95:72] is leftmost
// upsp_ac_wvalid  in   1     beat valid
// ac_upsp_wready  out  1     beat accepted when valid&ready
// ac_pix_data     out  24    serialised pixel
// ac_pix_valid    out  1     pixel valid
// ac_pix_ready    in   1     downstream ready
// ac_pix_sof      out  1     qualifies pixel (0,0) of a frame
// ac_pix_eol      out  1     qualifies the last pixel of a line
// ac_frame_done   out  1     1-cycle pulse after the last pixel of a frame is accepted
// BEHAVIOUR
// Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
// Reset values
// - FIFO empty, lane=0, col=0, row=0.
// - ac_pix_valid=0, sof=0, eol=0, frame_done=0, data=0.
// - ac_upsp_wready=1 (FIFO not full).
// Input side
// - ac_upsp_wready = !full; no full-bypass.
// - A push happens on wvalid & wready.
// Output side
// - ac_pix_valid = !empty.
// - ac_pix_data = lane pixel of the head entry; lane 0 is taken from [95:72], lane 3 from [23:0].
// - Pixel handshake (valid&ready) advances lane 0->1->2->3.
// - The handshake on lane 3 pops the head entry and sets lane to 0.
// - While valid&!ready, data, sof and eol stay stable.
// Latency
// - A beat pushed in cycle N shows its pix0 at cycle N+1 if the FIFO was empty.
// - A steady stream sustains 1 pixel/cycle.
// - Input throughput is 1 beat per 4 cycles.
// Simultaneous events
// - A push and a pop in the same cycle leave the count unchanged.
// - A push and a pop are both legal when the FIFO is full-1 or empty+1.
// - With the FIFO full, a pop in cycle N makes wready=1 in cycle N+1, because wready derives from the registered count.
// Position counters (advance on each pixel handshake)
// - col wraps at DST_IMG_WIDTH-1; when it wraps, row increments.
// - row wraps at DST_IMG_HEIGHT-1.
// - sof = valid & col==0 & row==0.
// - eol = valid & col==DST_IMG_WIDTH-1.
// - ac_frame_done is asserted in the cycle after the handshake where col and row both wrap.
// Reset mid-operation clears the FIFO, lane, col and row immediately. Beats held in the FIFO are dropped.
// Widths
// - col is $clog2(DST_IMG_WIDTH) bits; row is $clog2(DST_IMG_HEIGHT) bits.
// - FIFO count is $clog2(FIFO_DEPTH)+1 bits.
// STRUCTURE
// Shared package
// - localparams LANES=4, BEAT_WIDTH=LANES*BUFFER_WIDTH.
// - Function lane_sel(beat, idx) returning the 24-bit pixel, MSB lane first.
// Sub-module ac_wbeat_fifo: synchronous FIFO, BEAT_WIDTH x FIFO_DEPTH.
// - Registered pointers and count; full/empty flags; show-ahead head output.
// Top level: lane counter, col/row counters, marker logic.
// TESTING
// 1. Single beat 96'h111111_222222_333333_444444 with ac_pix_ready=1
//    -> data 111111,222222,333333,444444 on 4 consecutive cycles.
//    -> First pixel one cycle after the push; sof=1 on the first pixel only.
// 2. ac_pix_ready=0 with wvalid held high -> wready falls after exactly FIFO_DEPTH beats.
//    Releasing ready for one pixel -> no change in wready.
//    After 4 pixels (one pop) -> wready=1 the next cycle.
// 3. Random ac_pix_ready toggling across a full frame with DST_IMG_WIDTH=8, DST_IMG_HEIGHT=3
//    -> 24 pixels in order, eol at col 7 of each line.
//    -> ac_frame_done pulses once; the next frame's pixel (0,0) has sof=1.
// 4. ac_pix_ready held 0 for 5 cycles mid-beat (lane 2) -> data and eol stable; no lane advance.
// 5. rst_n pulsed low with 3 entries queued and lane=1
//    -> valid=0 and wready=1 asynchronously.
//    -> Next beat restarts at lane 0 with sof=1.
// 6. Push and pop in the same cycle with count=1 -> count stays 1; the pixel order is preserved.

Source files
------------

// File: rtl/ac_upsp_wbeat_pkg.sv
// Shared widths and lane extraction for the upsampler write-beat serializer.
package ac_upsp_wbeat_pkg;

    localparam int unsigned PIX_WIDTH  = 24;
    localparam int unsigned LANES      = 4;
    localparam int unsigned BEAT_WIDTH = LANES * PIX_WIDTH;

    // Lane 0 is the leftmost pixel and sits in the most significant slot.
    function automatic logic [PIX_WIDTH-1:0] lane_sel(input logic [BEAT_WIDTH-1:0] beat,
                                                      input logic [1:0] idx);
        logic [PIX_WIDTH-1:0] pix;
        case (idx)
            2'd0:    pix = beat[3*PIX_WIDTH +: PIX_WIDTH];
            2'd1:    pix = beat[2*PIX_WIDTH +: PIX_WIDTH];
            2'd2:    pix = beat[1*PIX_WIDTH +: PIX_WIDTH];
            default: pix = beat[0 +: PIX_WIDTH];
        endcase
        return pix;
    endfunction

endpackage

// File: rtl/ac_upsp_wbeat_serializer_fifo.sv
// Show-ahead synchronous FIFO holding whole write beats.
module ac_wbeat_fifo #(
    parameter int unsigned Width = 96,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth) + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; the count alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/ac_upsp_wbeat_serializer.sv
// Accepts 4-pixel write beats, buffers them and emits one pixel per handshake
// with frame/line position markers.
module ac_upsp_wbeat_serializer
    import ac_upsp_wbeat_pkg::*;
#(
    parameter int unsigned BUFFER_WIDTH   = 24,
    parameter int unsigned DST_IMG_WIDTH  = 3840,
    parameter int unsigned DST_IMG_HEIGHT = 2160,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [LANES*BUFFER_WIDTH-1:0] upsp_ac_wdata,
    input  logic                          upsp_ac_wvalid,
    output logic                          ac_upsp_wready,
    output logic [BUFFER_WIDTH-1:0]       ac_pix_data,
    output logic                          ac_pix_valid,
    input  logic                          ac_pix_ready,
    output logic                          ac_pix_sof,
    output logic                          ac_pix_eol,
    output logic                          ac_frame_done
);

    localparam int unsigned ColW = (DST_IMG_WIDTH > 1) ? $clog2(DST_IMG_WIDTH) : 1;
    localparam int unsigned RowW = (DST_IMG_HEIGHT > 1) ? $clog2(DST_IMG_HEIGHT) : 1;

    logic [BEAT_WIDTH-1:0] head;
    logic                  full, empty;
    logic                  push, pop, pix_hs;
    logic                  col_last, row_last;
    logic [1:0]            lane_q, lane_d;
    logic [ColW-1:0]       col_q, col_d;
    logic [RowW-1:0]       row_q, row_d;
    logic                  frame_done_q, frame_done_d;

    assign ac_upsp_wready = ~full;
    assign push           = upsp_ac_wvalid & ~full;
    assign ac_pix_valid   = ~empty;
    assign pix_hs         = ac_pix_valid & ac_pix_ready;
    assign pop            = pix_hs & (lane_q == 2'd3);

    ac_wbeat_fifo #(
        .Width (BEAT_WIDTH),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (push),
        .data_i  (upsp_ac_wdata),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    assign col_last = (col_q == ColW'(DST_IMG_WIDTH - 1));
    assign row_last = (row_q == RowW'(DST_IMG_HEIGHT - 1));

    always_comb begin
        lane_d       = lane_q;
        col_d        = col_q;
        row_d        = row_q;
        frame_done_d = 1'b0;
        if (pix_hs) begin
            lane_d = lane_q + 2'd1;
            col_d  = col_last ? '0 : col_q + 1'b1;
            if (col_last) begin
                row_d = row_last ? '0 : row_q + 1'b1;
            end
            frame_done_d = col_last & row_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q       <= '0;
            col_q        <= '0;
            row_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            lane_q       <= lane_d;
            col_q        <= col_d;
            row_q        <= row_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Data is forced to zero while nothing is queued so reset/idle output is clean.
    assign ac_pix_data   = ac_pix_valid ? lane_sel(head, lane_q) : '0;
    assign ac_pix_sof    = ac_pix_valid & (col_q == '0) & (row_q == '0);
    assign ac_pix_eol    = ac_pix_valid & col_last;
    assign ac_frame_done = frame_done_q;

endmodule

// File: tb/tb_ac_upsp_wbeat_serializer.sv
// Directed scoreboard bench for ac_upsp_wbeat_serializer on an 8x3 frame.
module tb_ac_upsp_wbeat_serializer;

    localparam int unsigned W = 8;
    localparam int unsigned H = 3;
    localparam int unsigned D = 4;

    typedef struct packed {
        logic [23:0] d;
        logic        sof;
        logic        eol;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [95:0] upsp_ac_wdata = '0;
    logic        upsp_ac_wvalid = 1'b0;
    logic        ac_upsp_wready;
    logic [23:0] ac_pix_data;
    logic        ac_pix_valid;
    logic        ac_pix_ready = 1'b0;
    logic        ac_pix_sof;
    logic        ac_pix_eol;
    logic        ac_frame_done;

    ac_upsp_wbeat_serializer #(
        .BUFFER_WIDTH   (24),
        .DST_IMG_WIDTH  (W),
        .DST_IMG_HEIGHT (H),
        .FIFO_DEPTH     (D)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .upsp_ac_wdata  (upsp_ac_wdata),
        .upsp_ac_wvalid (upsp_ac_wvalid),
        .ac_upsp_wready (ac_upsp_wready),
        .ac_pix_data    (ac_pix_data),
        .ac_pix_valid   (ac_pix_valid),
        .ac_pix_ready   (ac_pix_ready),
        .ac_pix_sof     (ac_pix_sof),
        .ac_pix_eol     (ac_pix_eol),
        .ac_frame_done  (ac_frame_done)
    );

    always #5 clk = ~clk;

    exp_t        exp_q[$];
    logic [95:0] src_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          mcol = 0;
    int          mrow = 0;
    int          fd_seen = 0;
    int          fd_model = 0;
    int          pix_id = 1;
    bit          fd_exp = 0;
    bit          src_en = 0;
    bit          rnd_ready = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Queue a beat of four fresh pixels, leftmost first.
    task automatic add_beat();
        logic [95:0] b;
        for (int i = 0; i < 4; i++) begin
            b[(3-i)*24 +: 24] = 24'(pix_id) ^ 24'hA50000;
            pix_id++;
        end
        src_q.push_back(b);
    endtask

    task automatic model_accept(input logic [95:0] b);
        logic [23:0] px [4];
        exp_t        e;
        px[0] = b[95:72];
        px[1] = b[71:48];
        px[2] = b[47:24];
        px[3] = b[23:0];
        for (int i = 0; i < 4; i++) begin
            e.d    = px[i];
            e.sof  = (mcol == 0) && (mrow == 0);
            e.eol  = (mcol == W - 1);
            e.last = (mcol == W - 1) && (mrow == H - 1);
            exp_q.push_back(e);
            if (mcol == W - 1) begin
                mcol = 0;
                mrow = (mrow == H - 1) ? 0 : mrow + 1;
            end else begin
                mcol++;
            end
        end
    endtask

    task automatic cycle();
        exp_t e;
        int   beats;
        @(negedge clk);
        beats = (exp_q.size() + 3) / 4;
        chk("pix_valid", 32'(ac_pix_valid), 32'(exp_q.size() != 0));
        chk("wready", 32'(ac_upsp_wready), 32'(beats < D));
        chk("frame_done", 32'(ac_frame_done), 32'(fd_exp));
        if (ac_frame_done) fd_seen++;
        fd_exp = 0;
        if (exp_q.size() != 0) begin
            e = exp_q[0];
            chk("pix_data", 32'(ac_pix_data), 32'(e.d));
            chk("pix_sof", 32'(ac_pix_sof), 32'(e.sof));
            chk("pix_eol", 32'(ac_pix_eol), 32'(e.eol));
            if (ac_pix_ready) begin
                void'(exp_q.pop_front());
                if (e.last) begin
                    fd_exp = 1;
                    fd_model++;
                end
            end
        end else begin
            chk("idle_data", 32'(ac_pix_data), 32'h0);
            chk("idle_sof", 32'(ac_pix_sof), 32'h0);
        end
        if (upsp_ac_wvalid && ac_upsp_wready) begin
            model_accept(upsp_ac_wdata);
            if (src_q.size() != 0 && src_q[0] == upsp_ac_wdata) void'(src_q.pop_front());
        end
        @(posedge clk);
        #1;
        if (rnd_ready) ac_pix_ready = 1'($urandom_range(0, 1));
        upsp_ac_wvalid = src_en && (src_q.size() != 0);
        upsp_ac_wdata  = (src_q.size() != 0) ? src_q[0] : '0;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && (exp_q.size() != 0 || (src_en && src_q.size() != 0)); i++) begin
            cycle();
        end
        cycle();
        chk("drain_empty", 32'(exp_q.size() + src_q.size()), 32'h0);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_valid", 32'(ac_pix_valid), 32'h0);
        chk("rst_wready", 32'(ac_upsp_wready), 32'h1);
        chk("rst_data", 32'(ac_pix_data), 32'h0);
        chk("rst_sof", 32'(ac_pix_sof), 32'h0);
        chk("rst_eol", 32'(ac_pix_eol), 32'h0);
        chk("rst_fd", 32'(ac_frame_done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: single known beat, streamed with ready high
        ac_pix_ready = 1'b1;
        src_q.push_back(96'h111111_222222_333333_444444);
        src_en = 1;
        upsp_ac_wvalid = 1'b1;
        upsp_ac_wdata  = src_q[0];
        drain();

        // 4: stall at lane 2 for 5 cycles
        ac_pix_ready = 1'b0;
        add_beat();
        repeat (2) cycle();
        ac_pix_ready = 1'b1;
        repeat (2) cycle();
        ac_pix_ready = 1'b0;
        repeat (5) cycle();
        chk("stall_remaining", 32'(exp_q.size()), 32'd2);
        ac_pix_ready = 1'b1;
        drain();

        // 2: back-pressure fills the FIFO, then one pop frees a slot
        ac_pix_ready = 1'b0;
        repeat (6) add_beat();
        repeat (8) cycle();
        chk("beats_held_back", 32'(src_q.size()), 32'd2);
        ac_pix_ready = 1'b1;
        cycle();
        ac_pix_ready = 1'b0;
        repeat (2) cycle();
        chk("one_px_no_slot", 32'(src_q.size()), 32'd2);
        ac_pix_ready = 1'b1;
        repeat (3) cycle();
        ac_pix_ready = 1'b0;
        cycle();
        chk("slot_freed", 32'(src_q.size()), 32'd1);
        ac_pix_ready = 1'b1;
        drain();

        // 3: random ready over more than a full frame
        repeat (8) add_beat();
        rnd_ready = 1;
        drain();
        rnd_ready = 0;
        ac_pix_ready = 1'b1;
        cycle();

        // 5: async reset with 3 beats queued and lane 1
        ac_pix_ready = 1'b0;
        repeat (3) add_beat();
        repeat (5) cycle();
        ac_pix_ready = 1'b1;
        cycle();
        ac_pix_ready = 1'b0;
        cycle();
        chk("pre_rst_queued", 32'(exp_q.size()), 32'd11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(ac_pix_valid), 32'h0);
        chk("async_wready", 32'(ac_upsp_wready), 32'h1);
        chk("async_sof", 32'(ac_pix_sof), 32'h0);
        exp_q.delete();
        src_q.delete();
        mcol = 0;
        mrow = 0;
        fd_exp = 0;
        upsp_ac_wvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        ac_pix_ready = 1'b1;
        add_beat();
        upsp_ac_wvalid = 1'b1;
        upsp_ac_wdata  = src_q[0];
        drain();

        // 6: push while the single queued beat is on lane 3
        ac_pix_ready = 1'b1;
        src_en = 0;
        add_beat();
        upsp_ac_wvalid = 1'b1;
        upsp_ac_wdata  = src_q[0];
        cycle();
        for (int i = 0; i < 20 && exp_q.size() > 1; i++) cycle();
        add_beat();
        upsp_ac_wvalid = 1'b1;
        upsp_ac_wdata  = src_q[0];
        cycle();
        chk("same_cycle_queued", 32'(exp_q.size()), 32'd4);
        src_en = 1;
        drain();

        chk("frame_done_pulses", 32'(fd_seen), 32'(fd_model));
        chk("frame_done_count", 32'(fd_model), 32'd2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
